uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin scheduler that shares one `UART_transmitter` between `NREQ` byte producers. It accepts bytes over per-requester valid/ready handshakes and latches the winning byte. It then pulses `tx_start` with the byte on `tx_din` and holds off further grants until the transmitter reports `tx_done_tick`. It sits directly upstream of `UART_transmitter` and drives its `tx_start`/`tx_din` inputs.

## Interface
- `NREQ`, default 4: number of requesters, 2..16.
- `IDW`, default `$clog2(NREQ)`: width of the grant index.
- `clk`  in  1: single clock, shared with `UART_transmitter`.
- `reset_n`  in  1: reset, synchronous and active-low.
- `req_valid`  in  NREQ: requester i has a byte.
- `req_data`  in  8*NREQ: byte of requester i at bits [8i+7:8i].
- `req_last`  in  NREQ: last byte of a packet; used only with `UART_TX_ARB_LOCK_EN`.
- `req_ready`  out  NREQ: one-hot accept; the byte transfers when `req_valid[i] & req_ready[i]` at a rising edge.
- `tx_start`  out  1: one-cycle start pulse to the transmitter.
- `tx_din`  out  8: byte to the transmitter; stable from the `tx_start` cycle until the next acceptance.
- `tx_done_tick`  in  1: transmitter end-of-frame pulse.
- `busy`  out  1: high whenever state is not IDLE.
- `grant_id`  out  IDW: index of the requester whose byte is in flight or was last sent.

## Operation
- States: IDLE, START, WAIT.
- **IDLE:**
  - `req_ready` is combinational. It is one-hot on the round-robin winner among asserted `req_valid`, and 0 if none are asserted.
  - On acceptance: latch `req_data` slice into `tx_din`, set `grant_id` to the winner, set `last_ptr` to the winner, go to START.
- **START:** `tx_start`=1 for exactly this cycle; `req_ready`=0; go to WAIT.
- **WAIT:** `req_ready`=0. On `tx_done_tick`=1, go to IDLE.
- `tx_done_tick` is ignored in IDLE and START.
- **Round-robin rule:**
  - Search order is `last_ptr+1`, `last_ptr+2`, … modulo NREQ.
  - The first asserted requester wins.
  - The last winner has the lowest priority next time.
- Index arithmetic is IDW bits with an explicit wrap at NREQ, which need not be a power of 2.
- A requester may drop `req_valid` before it is accepted; there is no penalty and the pointer is unchanged.
- Reset values: state IDLE, `tx_start`=0, `tx_din`=8'h00, `busy`=0, `grant_id`=0, `last_ptr`=NREQ-1 (requester 0 has first priority), lock flag=0.
- **Reset mid-operation:**
  - The block returns to IDLE on the next edge.
  - The in-flight byte is abandoned; it is not re-offered.
  - A `tx_done_tick` seen after reset is ignored.

## Timing
- **Acceptance to start:** acceptance at edge N puts `tx_start`=1 during cycle N+1. `tx_din` is valid in that same cycle.
- **Done to next accept:** `tx_done_tick` high at edge M puts the block in IDLE during cycle M+1, where the next acceptance can occur. A back-to-back gap is therefore 2 cycles beyond the frame time.
- `req_ready` is never asserted outside IDLE and is never asserted for more than one requester.
- Simultaneous `req_valid` on all inputs with `last_ptr`=NREQ-1 grants in order 0,1,…,NREQ-1,0.
- Throughput: 1 byte per frame + 2 cycles.

## Configuration
- `UART_TX_ARB_LOCK_EN` defined:
  - After accepting a byte with `req_last`=0, the lock flag is set.
  - The next IDLE grants only the same `grant_id`; other requesters wait even if valid.
  - The lock clears on acceptance of a byte with `req_last`=1.
  - While locked, `last_ptr` is not advanced, so fairness resumes after the packet.
- `UART_TX_ARB_LOCK_EN` undefined:
  - `req_last` is ignored, there is no lock flag, and arbitration runs per byte.

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum (IDLE, START, WAIT);
  - the `UART_BYTE_W`=8 constant;
  - a function `rr_next(ptr, NREQ)` for the wrapping increment.
- Sub-module `uart_rr_pick` is combinational and has no state. It takes `req` and `last_ptr` (plus the lock mask when `UART_TX_ARB_LOCK_EN` is defined) and returns a one-hot grant, the index, and an `any` flag.
- The top level holds the FSM and the registers.

## Test plan
- **Single requester:** reset, then `req_valid`=4'b0010 with byte 8'h36 → `req_ready[1]` in that cycle, `tx_start` pulse next cycle with `tx_din`=8'h36 and `grant_id`=1; `busy` high until 1 cycle after `tx_done_tick`.
- **All four requesters** hold bytes 8'hA0..8'hA3 → transmit order is A0, A1, A2, A3, A0. Each `tx_start` follows the prior `tx_done_tick` by exactly 2 cycles.
- **Wrap:** with `last_ptr`=3, only requesters 3 and 0 valid → 0 is granted, then 3.
- **Spurious done:** `tx_done_tick` asserted in IDLE and in START → no state change, no extra `tx_start`.
- **Reset in WAIT:** `reset_n`=0 for one edge → outputs at reset values. With requester 2 valid, it is accepted at the first IDLE edge after release, and requester 0 wins if also valid.
- **With `UART_TX_ARB_LOCK_EN`:** requester 1 sends 3 bytes with `req_last`=0,0,1 while requester 2 is valid → all three bytes of requester 1 precede requester 2. Without the macro, the order is 1, 2, 1, 2, 1.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM states, byte width
// and the wrapping round-robin increment.
package uart_arb_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Next index after ptr, wrapping at nreq (nreq need not be a power of 2).
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
    return (ptr + 1 >= nreq) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches last_ptr+1, last_ptr+2, ... and
// returns the first asserted request. Lock mask input exists with UART_TX_ARB_LOCK_EN.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_ptr,
`ifdef UART_TX_ARB_LOCK_EN
  input  logic [NREQ-1:0] lock_mask,
`endif
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [NREQ-1:0] req_m;
  logic [IDW-1:0]  p;

`ifdef UART_TX_ARB_LOCK_EN
  assign req_m = req & lock_mask;
`else
  assign req_m = req;
`endif

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    p     = last_ptr;
    for (int k = 0; k < NREQ; k++) begin
      p = IDW'(rr_next(32'(p), NREQ));
      if (!any && req_m[p]) begin
        any = 1'b1;
        idx = p;
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte producers.
// Define UART_TX_ARB_LOCK_EN to keep the grant on one requester until req_last.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]             req_last,
  output logic [NREQ-1:0]             req_ready,
  output logic                        tx_start,
  output logic [UART_BYTE_W-1:0]      tx_din,
  input  logic                        tx_done_tick,
  output logic                        busy,
  output logic [IDW-1:0]              grant_id
);

  // Handshake: a byte moves from requester i when req_valid[i] & req_ready[i]
  // at a rising edge; req_ready is one-hot and only ever asserted in IDLE.

  arb_state_e             state, state_nxt;
  logic [NREQ-1:0]        grant;
  logic [IDW-1:0]         win_idx;
  logic                   win_any;
  logic [IDW-1:0]         last_ptr;
  logic                   accept;
  logic [UART_BYTE_W-1:0] req_bytes [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[UART_BYTE_W*i +: UART_BYTE_W];
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic            locked;
  logic [NREQ-1:0] lock_mask;

  assign lock_mask = locked ? (NREQ'(1) << grant_id) : '1;
`else
  logic unused_last;

  assign unused_last = ^req_last;
`endif

  uart_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req       (req_valid),
    .last_ptr  (last_ptr),
`ifdef UART_TX_ARB_LOCK_EN
    .lock_mask (lock_mask),
`endif
    .grant     (grant),
    .idx       (win_idx),
    .any       (win_any)
  );

  assign accept = (state == IDLE) && win_any;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    tx_start  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = grant;
        if (win_any) state_nxt = START;
      end
      START: begin
        tx_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (tx_done_tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      tx_din   <= '0;
      grant_id <= '0;
      last_ptr <= IDW'(NREQ - 1);
`ifdef UART_TX_ARB_LOCK_EN
      locked   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        tx_din   <= req_bytes[win_idx];
        grant_id <= win_idx;
`ifdef UART_TX_ARB_LOCK_EN
        // Pointer frozen mid-packet so fairness resumes from the packet start.
        if (!locked) last_ptr <= win_idx;
        locked <= !req_last[win_idx];
`else
        last_ptr <= win_idx;
`endif
      end
    end
  end

endmodule
